// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, imem request/ready handshake and IF/ID register.
// ID-stage redirects squash the wrong-path fetch; an unanswered request is drained before refetching.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] pc
);

  // state | meaning
  // FETCH | request at pc; capture response into IF/ID, or squash on redirect
  // DRAIN | re-present the abandoned address until it completes; response discarded
  typedef enum logic {ST_FETCH = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_target;

  // IF/ID always holds a bubble in DRAIN, so a redirect can only arise in FETCH.
  assign w_redirect   = r_valid & ~stall & (Jump | PCSrc);
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_jump_tgt   = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
  assign w_branch_tgt = r_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_target     = Jump ? w_jump_tgt : w_branch_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: if (w_redirect && !imem_ready) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (imem_ready) w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = ~rst;
    imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_instr      <= '0;
      r_pc_plus4   <= '0;
      r_valid      <= 1'b0;
    end else if (r_state == ST_DRAIN) begin
      if (!stall) begin
        r_instr    <= '0;
        r_pc_plus4 <= '0;
        r_valid    <= 1'b0;
      end
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      if (!imem_ready) r_drain_addr <= r_pc;
    end else if (!stall) begin
      if (imem_ready) begin
        r_instr    <= imem_rdata;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
        r_pc       <= w_pc_plus4;
      end else begin
        r_instr    <= '0;
        r_pc_plus4 <= '0;
        r_valid    <= 1'b0;
      end
    end
  end

  assign pc             = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc_plus4;
  assign if_id_valid    = r_valid;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory request/ready interface, and holds the IF/ID pipeline register. It consumes the ID-stage branch decision (`PCSrc`) and `Jump` from the branch/jump detection logic, computes the redirect target from the IF/ID instruction it holds, and squashes the wrong-path fetch. It also handles hazard-unit stalls and instruction-memory wait states.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCSrc`  in  1  conditional branch taken, from branch/jump detection.
- `Jump`  in  1  unconditional jump decoded in ID.
- `stall`  in  1  hazard-unit stall: hold PC and IF/ID.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  fetch address.
- `imem_ready`  in  1  `imem_rdata` valid; the request completes this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `if_id_instr`  out  32  IF/ID instruction; 0 when bubble.
- `if_id_pc_plus4`  out  32  IF/ID PC+4.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `pc`  out  32  current PC register.

## Operation
- Reset values: `pc`=RESET_PC, state=FETCH, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, drain address=0. `imem_req`=0 while `rst`=1.
- redirect = `if_id_valid` & !`stall` & (`Jump` | `PCSrc`). `Jump` has priority over `PCSrc`.
- Jump target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- Branch target = if_id_pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), where imm = if_id_instr[15:0]. The sum wraps modulo 2^32.
- Per-cycle priority: `rst` > redirect > `stall` > normal.

State FETCH: `imem_req`=1, `imem_addr`=`pc`.
- redirect & `imem_ready`: `pc`←target; IF/ID←bubble; `imem_rdata` is discarded; stay in FETCH.
- redirect & !`imem_ready`: drain address←`pc`; `pc`←target; IF/ID←bubble; go to DRAIN.
- `stall`: `pc` and IF/ID hold; any returned data is discarded and the address is refetched.
- `imem_ready`: IF/ID←{`imem_rdata`, `pc`+4, 1}; `pc`←`pc`+4.
- !`imem_ready`: IF/ID←bubble (instr=0, valid=0, pc_plus4=0); `pc` holds.

State DRAIN: `imem_req`=1, `imem_addr`=drain address (the old address is held until the memory accepts it).
- On `imem_ready`: data is discarded; go to FETCH.
- `pc` already holds the target.
- IF/ID loads a bubble every DRAIN cycle unless `stall`=1, in which case it holds.
- Redirect cannot occur in DRAIN: IF/ID holds a bubble.

## Timing
- Fetch latency: an instruction returned with `imem_ready` in cycle N appears on `if_id_*` in N+1.
- Redirect asserted in cycle N: `imem_addr` = target in N+1 (FETCH path) or in the cycle after the drain completes. The branch delay slot is squashed, costing exactly one bubble with zero-wait memory.
- `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0.
- `rst` in any state, including DRAIN, returns to FETCH at RESET_PC on the next edge. The outstanding response is abandoned.
- `stall` & (`PCSrc`|`Jump`) is not a redirect; the branch re-evaluates once the stall drops.

## Test plan
- Reset, `imem_ready`=1, rdata=A,B,C → `imem_addr` 0x0, 0x4, 0x8. IF/ID shows (A, 0x4, 1) then (B, 0x8, 1).
- `imem_ready`=0 for 2 cycles at pc=0x8 → `imem_addr` held at 0x8, two bubbles (valid=0, instr=0), resume with pc_plus4=0xC.
- IF/ID instr imm=16'hFFFE, pc_plus4=0x10, `PCSrc`=1 → next `imem_addr`=0x8, IF/ID bubble. With imm=16'h7FFF, pc_plus4=0xFFFF_FFF0 → target 0x0001_FFEC (wrap).
- IF/ID index=26'h0000040, pc_plus4=0x1000_0004, `Jump`=1 and `PCSrc`=1 → target 0x1000_0100 (jump wins).
- Redirect with `imem_ready`=0 at pc=0x20 → DRAIN holds `imem_addr`=0x20 until ready. That data is discarded, then target is fetched. `rst` mid-DRAIN → `imem_addr`=RESET_PC next cycle.
- `stall`=1 with `PCSrc`=1 for 2 cycles → `pc` and IF/ID unchanged, no redirect. `stall`=0 → redirect taken.
